// File: rtl/ps2_pkg.sv
// Shared constants and prefix-state encoding for the PS/2 scancode path.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

  // Keyboard replies and error codes that never represent a key.
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_ECHO      = 8'hEE;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_OVERRUN0  = 8'h00;
  localparam logic [7:0] PS2_OVERRUN1  = 8'hFF;

  localparam int PAUSE_TAIL_LEN = 7;

  typedef enum logic [2:0] {
    PFX_IDLE,
    PFX_E0,
    PFX_F0,
    PFX_E0F0,
    PFX_E1
  } pfx_state_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_OVERRUN0) || (b == PS2_OVERRUN1);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and filters the raw lines, deserialises
// 11-bit frames and reports each good byte or framing/timeout error.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          filt_clk_reg;
  logic          filt_prev_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [TW-1:0] to_cnt_reg;
  logic [7:0]    rx_byte_reg;
  logic          byte_valid_reg;
  logic          byte_error_reg;

  logic fall_edge;
  logic data_bit;

  assign fall_edge = filt_prev_reg & ~filt_clk_reg;
  assign data_bit  = data_sync_reg[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_reg   <= 2'b11;
      data_sync_reg  <= 2'b11;
      filt_clk_reg   <= 1'b1;
      filt_prev_reg  <= 1'b1;
      filt_cnt_reg   <= '0;
      bit_cnt_reg    <= 4'd0;
      shift_reg      <= 8'h00;
      parity_reg     <= 1'b0;
      to_cnt_reg     <= '0;
      rx_byte_reg    <= 8'h00;
      byte_valid_reg <= 1'b0;
      byte_error_reg <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2clk};
      data_sync_reg <= {data_sync_reg[0], ps2data};
      filt_prev_reg <= filt_clk_reg;

      // Any sample matching the current filtered level restarts the run count.
      if (clk_sync_reg[1] == filt_clk_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
        filt_clk_reg <= clk_sync_reg[1];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end

      byte_valid_reg <= 1'b0;
      byte_error_reg <= 1'b0;

      if (fall_edge) begin
        to_cnt_reg <= '0;
        case (bit_cnt_reg)
          4'd0: begin
            if (!data_bit) bit_cnt_reg <= 4'd1;
          end
          4'd9: begin
            parity_reg  <= data_bit;
            bit_cnt_reg <= 4'd10;
          end
          4'd10: begin
            bit_cnt_reg <= 4'd0;
            if (data_bit && ((^shift_reg) ^ parity_reg)) begin
              rx_byte_reg    <= shift_reg;
              byte_valid_reg <= 1'b1;
            end else begin
              byte_error_reg <= 1'b1;
            end
          end
          default: begin
            shift_reg   <= {data_bit, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
          end
        endcase
      end else if (bit_cnt_reg != 4'd0) begin
        if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          to_cnt_reg     <= '0;
          bit_cnt_reg    <= 4'd0;
          byte_error_reg <= 1'b1;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign rx_byte    = rx_byte_reg;
  assign byte_valid = byte_valid_reg;
  assign byte_error = byte_error_reg;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 keyboard front end: strips E0/F0/E1 prefixes from received bytes and
// emits one-cycle make/break events with sticky scancode/extended/released.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       scan_received,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       frame_error
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       byte_error;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2clk    (ps2clk),
    .ps2data   (ps2data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .byte_error(byte_error)
  );

  pfx_state_t state_reg, state_next;
  logic [2:0] skip_reg, skip_next;
  logic       emit, emit_ext, emit_rel;

  logic       scan_received_reg;
  logic [7:0] scancode_reg;
  logic       extended_reg;
  logic       released_reg;
  logic       frame_error_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= PFX_IDLE;
      skip_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      skip_reg  <= skip_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    skip_next  = skip_reg;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_rel   = 1'b0;
    if (byte_error) begin
      // A damaged frame may have been a prefix; never let it tag a later key.
      state_next = PFX_IDLE;
    end else if (byte_valid) begin
      case (state_reg)
        PFX_IDLE: begin
          if (rx_byte == PS2_PFX_EXT) begin
            state_next = PFX_E0;
          end else if (rx_byte == PS2_PFX_BRK) begin
            state_next = PFX_F0;
          end else if (rx_byte == PS2_PFX_PAUSE) begin
            state_next = PFX_E1;
            skip_next  = 3'(PAUSE_TAIL_LEN);
          end else if (!is_ignored(rx_byte)) begin
            emit = 1'b1;
          end
        end
        PFX_E0: begin
          state_next = PFX_IDLE;
          if (rx_byte == PS2_PFX_BRK) begin
            state_next = PFX_E0F0;
          end else if (rx_byte != PS2_PFX_EXT && rx_byte != PS2_PFX_PAUSE) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        PFX_F0: begin
          state_next = PFX_IDLE;
          emit       = 1'b1;
          emit_rel   = 1'b1;
        end
        PFX_E0F0: begin
          state_next = PFX_IDLE;
          emit       = 1'b1;
          emit_ext   = 1'b1;
          emit_rel   = 1'b1;
        end
        PFX_E1: begin
          skip_next = skip_reg - 3'd1;
          if (skip_reg == 3'd1) state_next = PFX_IDLE;
        end
        default: state_next = PFX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_received_reg <= 1'b0;
      scancode_reg      <= 8'h00;
      extended_reg      <= 1'b0;
      released_reg      <= 1'b0;
      frame_error_reg   <= 1'b0;
    end else begin
      scan_received_reg <= emit;
      frame_error_reg   <= byte_error;
      if (emit) begin
        scancode_reg <= rx_byte;
        extended_reg <= emit_ext;
        released_reg <= emit_rel;
      end
    end
  end

  assign scan_received = scan_received_reg;
  assign scancode      = scancode_reg;
  assign extended      = extended_reg;
  assign released      = released_reg;
  assign frame_error   = frame_error_reg;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: drives bit-level PS/2 frames and
// checks decoded events, errors, timeout, glitch rejection and reset.
module tb_ps2_scancode_decoder;

  localparam int TO = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic       scan_received;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       frame_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ev_cnt = 0;
  int err_cnt = 0;
  int ev_cycle = 0;
  int stop_cyc = 0;

  ps2_scancode_decoder #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2clk       (ps2clk),
    .ps2data      (ps2data),
    .scan_received(scan_received),
    .scancode     (scancode),
    .extended     (extended),
    .released     (released),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (scan_received) begin
      ev_cnt   = ev_cnt + 1;
      ev_cycle = cyc;
    end
    if (frame_error) err_cnt = err_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit cell is 40 clk high then 40 clk low; glitches are 3-clk spikes.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit glitch);
    logic [10:0] fr;
    fr = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (glitch) begin
        wait_clk(5); ps2clk = 1'b0; wait_clk(3); ps2clk = 1'b1; wait_clk(12);
      end else begin
        wait_clk(20);
      end
      ps2data = fr[i];
      wait_clk(20);
      ps2clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      if (glitch) begin
        wait_clk(20); ps2clk = 1'b1; wait_clk(3); ps2clk = 1'b0; wait_clk(17);
      end else begin
        wait_clk(40);
      end
      ps2clk = 1'b1;
    end
    wait_clk(20);
    ps2data = 1'b1;
    wait_clk(100);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wait_clk(5);
    checks++; if (scan_received !== 1'b0) begin errors++; $display("FAIL reset_scan_received: got %b exp 0", scan_received); end
    checks++; if (scancode !== 8'h00) begin errors++; $display("FAIL reset_scancode: got %h exp 00", scancode); end
    checks++; if (extended !== 1'b0) begin errors++; $display("FAIL reset_extended: got %b exp 0", extended); end
    checks++; if (released !== 1'b0) begin errors++; $display("FAIL reset_released: got %b exp 0", released); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b exp 0", frame_error); end
    rst = 1'b1;
    wait_clk(20);
    $display("reset: outputs checked");
  endtask

  task automatic test_make();
    int e0;
    int lat;
    e0 = ev_cnt;
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    lat = ev_cycle - stop_cyc;
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL make_events: got %0d exp 1", ev_cnt - e0); end
    checks++; if (lat < 2 || lat > 30) begin errors++; $display("FAIL make_latency: got %0d exp 2..30", lat); end
    checks++; if (scancode !== 8'h1C) begin errors++; $display("FAIL make_code: got %h exp 1c", scancode); end
    checks++; if ({extended, released} !== 2'b00) begin errors++; $display("FAIL make_flags: got %b exp 00", {extended, released}); end
    wait_clk(200);
    checks++; if (scancode !== 8'h1C) begin errors++; $display("FAIL make_hold: got %h exp 1c", scancode); end
    $display("make 1C: code=%h ext=%b rel=%b latency=%0d", scancode, extended, released, lat);
  endtask

  task automatic test_ext_break();
    int e0;
    e0 = ev_cnt;
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    checks++; if (ev_cnt - e0 !== 0) begin errors++; $display("FAIL extbrk_prefix_events: got %0d exp 0", ev_cnt - e0); end
    send_frame(8'h75, 1'b0, 11, 1'b0);
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL extbrk_events: got %0d exp 1", ev_cnt - e0); end
    checks++; if (scancode !== 8'h75) begin errors++; $display("FAIL extbrk_code: got %h exp 75", scancode); end
    checks++; if ({extended, released} !== 2'b11) begin errors++; $display("FAIL extbrk_flags: got %b exp 11", {extended, released}); end
    $display("E0 F0 75: code=%h ext=%b rel=%b", scancode, extended, released);
  endtask

  task automatic test_parity_error();
    int e0;
    int r0;
    e0 = ev_cnt;
    r0 = err_cnt;
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    checks++; if (err_cnt - r0 !== 1) begin errors++; $display("FAIL parity_error_pulse: got %0d exp 1", err_cnt - r0); end
    checks++; if (ev_cnt - e0 !== 0) begin errors++; $display("FAIL parity_no_event: got %0d exp 0", ev_cnt - e0); end
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL parity_recover_events: got %0d exp 1", ev_cnt - e0); end
    checks++; if (scancode !== 8'h1C) begin errors++; $display("FAIL parity_recover_code: got %h exp 1c", scancode); end
    checks++; if ({extended, released} !== 2'b01) begin errors++; $display("FAIL parity_recover_flags: got %b exp 01", {extended, released}); end
    $display("bad parity then F0 1C: code=%h ext=%b rel=%b", scancode, extended, released);
  endtask

  task automatic test_timeout();
    int e0;
    int r0;
    e0 = ev_cnt;
    r0 = err_cnt;
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    send_frame(8'h5A, 1'b0, 5, 1'b0);
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL timeout_early: got %0d exp 0", err_cnt - r0); end
    wait_clk(TO + 100);
    checks++; if (err_cnt - r0 !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d exp 1", err_cnt - r0); end
    send_frame(8'h29, 1'b0, 11, 1'b0);
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_recover_events: got %0d exp 1", ev_cnt - e0); end
    checks++; if (scancode !== 8'h29) begin errors++; $display("FAIL timeout_recover_code: got %h exp 29", scancode); end
    checks++; if ({extended, released} !== 2'b00) begin errors++; $display("FAIL timeout_recover_flags: got %b exp 00", {extended, released}); end
    $display("timeout then 29: code=%h ext=%b rel=%b", scancode, extended, released);
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    int e0;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    e0 = ev_cnt;
    for (int i = 0; i < 8; i++) send_frame(seq[i], 1'b0, 11, 1'b0);
    checks++; if (ev_cnt - e0 !== 0) begin errors++; $display("FAIL pause_swallowed: got %0d exp 0", ev_cnt - e0); end
    send_frame(8'h16, 1'b0, 11, 1'b0);
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL pause_after_events: got %0d exp 1", ev_cnt - e0); end
    checks++; if (scancode !== 8'h16) begin errors++; $display("FAIL pause_after_code: got %h exp 16", scancode); end
    checks++; if ({extended, released} !== 2'b00) begin errors++; $display("FAIL pause_after_flags: got %b exp 00", {extended, released}); end
    $display("pause then 16: code=%h ext=%b rel=%b", scancode, extended, released);
  endtask

  task automatic test_ignored();
    int e0;
    e0 = ev_cnt;
    send_frame(8'hAA, 1'b0, 11, 1'b0);
    send_frame(8'h00, 1'b0, 11, 1'b0);
    send_frame(8'hFF, 1'b0, 11, 1'b0);
    checks++; if (ev_cnt - e0 !== 0) begin errors++; $display("FAIL ignored_codes: got %0d exp 0", ev_cnt - e0); end
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'h12, 1'b0, 11, 1'b0);
    checks++; if (scancode !== 8'h12) begin errors++; $display("FAIL fake_shift_code: got %h exp 12", scancode); end
    checks++; if ({extended, released} !== 2'b10) begin errors++; $display("FAIL fake_shift_flags: got %b exp 10", {extended, released}); end
    $display("ignored codes then E0 12: events=%0d code=%h ext=%b", ev_cnt - e0, scancode, extended);
  endtask

  task automatic test_glitch_reset();
    int e0;
    int r0;
    e0 = ev_cnt;
    r0 = err_cnt;
    send_frame(8'h4B, 1'b0, 11, 1'b1);
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL glitch_events: got %0d exp 1", ev_cnt - e0); end
    checks++; if (scancode !== 8'h4B) begin errors++; $display("FAIL glitch_code: got %h exp 4b", scancode); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL glitch_errors: got %0d exp 0", err_cnt - r0); end
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'h33, 1'b0, 5, 1'b0);
    rst = 1'b0;
    wait_clk(4);
    checks++; if ({scan_received, extended, released, frame_error} !== 4'b0000) begin errors++; $display("FAIL midreset_flags: got %b exp 0000", {scan_received, extended, released, frame_error}); end
    checks++; if (scancode !== 8'h00) begin errors++; $display("FAIL midreset_code: got %h exp 00", scancode); end
    rst = 1'b1;
    wait_clk(20);
    e0 = ev_cnt;
    r0 = err_cnt;
    send_frame(8'h12, 1'b0, 11, 1'b0);
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL postreset_events: got %0d exp 1", ev_cnt - e0); end
    checks++; if (scancode !== 8'h12) begin errors++; $display("FAIL postreset_code: got %h exp 12", scancode); end
    checks++; if ({extended, released} !== 2'b00) begin errors++; $display("FAIL postreset_flags: got %b exp 00", {extended, released}); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL postreset_errors: got %0d exp 0", err_cnt - r0); end
    $display("glitch 4B, mid-frame reset, then 12: code=%h ext=%b rel=%b", scancode, extended, released);
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_break();
    test_parity_error();
    test_timeout();
    test_pause();
    test_ignored();
    test_glitch_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
